muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Sequencer between the EX stage and the ALU's multi-cycle serial divider. It detects divide and remainder operations, latches the operands, and pulses the divider start. While the divider runs it stalls the pipeline, then captures the result and presents it for exactly one cycle. It also handles flush, watchdog timeout, and an optional fast path for divide-by-zero and signed overflow. Multiply and base ALU ops pass through with zero added latency.

## Interface
- DIV_TIMEOUT, 40: max WAIT cycles before abort (1..255)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- i_valid  in  1  EX holds a valid op
- i_alum  in  2  op class; 2'b11 = divide class
- i_alucontrol  in  3  bit0 = 1 remainder / 0 quotient; bit2 = 1 unsigned / 0 signed
- i_a, i_b  in  32  operands from EX
- i_flush  in  1  pipeline flush
- o_a, o_b  out  32  operands to ALU (latched during div, else i_a/i_b)
- o_alum  out  2  to ALU (latched during div, else i_alum)
- o_alucontrol  out  3  to ALU (latched during div, else i_alucontrol)
- o_div_start  out  1  one-cycle start pulse to divider
- o_div_flush  out  1  one-cycle abort pulse to divider
- i_div_busy  in  1  divider busy
- i_div_valid  in  1  divider result valid (one cycle)
- i_div_result  in  32  ALU result_out
- o_stall  out  1  freeze IF/ID/EX
- o_result  out  32  captured div/rem result
- o_result_valid  out  1  o_result valid; EX muxes it in
- o_timeout  out  1  sticky; set on watchdog abort, cleared only by reset

## Operation
- is_div = i_valid & (i_alum == 2'b11).
- States: IDLE, START, WAIT, DONE. Reset: IDLE; all registered outputs 0; latches 0; counter 0.
- IDLE:
  - If is_div & ~i_flush: latch a, b, alum, alucontrol. Go to START, or to DONE when the fast path hits.
  - Otherwise stay in IDLE with pass-through.
- START:
  - o_div_start = 1 for exactly this cycle; clear the counter; go to WAIT.
  - If i_div_busy is already high, still go to WAIT (the divider ignores the start).
- WAIT:
  - Counter increments each cycle.
  - On i_div_valid: result <= i_div_result; go to DONE.
  - When the counter reaches DIV_TIMEOUT-1 without i_div_valid: o_div_flush = 1 for one cycle, o_timeout <= 1, result <= 0, go to DONE.
- DONE:
  - o_result_valid = 1 and o_stall = 0; go to IDLE.
  - A new div is not accepted in DONE.
- o_stall = (IDLE & is_div & ~i_flush) | START | WAIT.
- Flush:
  - i_flush in START or WAIT: o_div_flush = 1 that cycle, go to IDLE, no result.
  - i_flush in DONE: o_result_valid is gated to 0.
  - Flush has priority over i_div_valid in the same cycle.
- o_div_start and o_div_flush are never high in the same cycle.
- Reset mid-operation: immediate return to IDLE; no flush pulse is issued. The divider shares the same reset.

## Timing
- Accepted div in cycle T:
  - o_div_start at T+1.
  - WAIT from T+2.
  - i_div_valid at cycle W gives o_result_valid at W+1.
  - o_stall is high from T through W.
- Fast path: accept at T, o_result_valid at T+1, stall only at T.
- Non-div ops: no stall, combinational pass-through.
- Back-to-back divs: the second is accepted in the IDLE cycle after DONE.
- o_result holds its value until the next capture.

## Configuration
- Macro DIV_FASTPATH_EN.
  - Defined: in IDLE, resolve special cases without starting the divider and go straight to DONE:
    - b == 0: quotient 32'hFFFFFFFF, remainder = a.
    - Signed a == 32'h80000000 with b == 32'hFFFFFFFF: quotient 32'h80000000, remainder 0.
  - Undefined: every div goes through START/WAIT, and special-case values are whatever the divider returns.

## Test plan
- Unsigned div a=100, b=7; divider valid after 33 cycles -> one o_div_start pulse at T+1, o_stall high T..W, o_result_valid at W+1 with o_result=14. Remainder op -> 2.
- ADD with i_alum=00, 3 back-to-back -> o_stall never asserted; o_a/o_b mirror inputs each cycle.
- Flush in the 5th WAIT cycle -> o_div_flush one cycle, state IDLE next cycle, no o_result_valid. A late i_div_valid is ignored.
- Divider never returns valid, DIV_TIMEOUT=40 -> o_div_flush at WAIT cycle 40, o_timeout=1, o_result_valid with o_result=0.
- DIV_FASTPATH_EN defined:
  - a=5, b=0 quotient -> o_result_valid at T+1 with 32'hFFFFFFFF, no o_div_start.
  - Signed 32'h80000000 / 32'hFFFFFFFF -> 32'h80000000.
  - Same stimulus without the macro -> full divider path.
- rst asserted in WAIT -> all outputs 0 immediately; after release, a new div is accepted normally.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// Bundle of EX-stage and divider-side signals for the muldiv_seq sequencer.
// The slave view belongs to the sequencer; the master view drives it.
interface muldiv_seq_if;
  logic        i_valid;
  logic [1:0]  i_alum;
  logic [2:0]  i_alucontrol;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        i_flush;
  logic [31:0] o_a;
  logic [31:0] o_b;
  logic [1:0]  o_alum;
  logic [2:0]  o_alucontrol;
  logic        o_div_start;
  logic        o_div_flush;
  logic        i_div_busy;
  logic        i_div_valid;
  logic [31:0] i_div_result;
  logic        o_stall;
  logic [31:0] o_result;
  logic        o_result_valid;
  logic        o_timeout;

  modport slave (
    input  i_valid, i_alum, i_alucontrol, i_a, i_b, i_flush,
    input  i_div_busy, i_div_valid, i_div_result,
    output o_a, o_b, o_alum, o_alucontrol, o_div_start, o_div_flush,
    output o_stall, o_result, o_result_valid, o_timeout
  );

  modport master (
    output i_valid, i_alum, i_alucontrol, i_a, i_b, i_flush,
    output i_div_busy, i_div_valid, i_div_result,
    input  o_a, o_b, o_alum, o_alucontrol, o_div_start, o_div_flush,
    input  o_stall, o_result, o_result_valid, o_timeout
  );
endinterface

// File: rtl/muldiv_seq.sv
// Sequencer between EX and the serial divider: latches operands, starts the
// divider, stalls until a result/timeout/flush. Optional macro DIV_FASTPATH_EN.
module muldiv_seq #(
  parameter int unsigned DIV_TIMEOUT = 40
) (
  input logic         clk,
  input logic         rst,
  muldiv_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_START = 2'b01,
    S_WAIT  = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  localparam logic [7:0] TMO_LAST = 8'(DIV_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [1:0]  alum_q, alum_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic        timeout_q, timeout_d;

  logic        is_div_s;
  logic        accept_s;
  logic        tmo_hit_s;

`ifdef DIV_FASTPATH_EN
  // Special cases the divider would otherwise spend a full run on.
  function automatic logic fast_hit(input logic [31:0] a, input logic [31:0] b,
                                    input logic [2:0] ctrl);
    fast_hit = (b == 32'h0000_0000) ||
               (!ctrl[2] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] fast_value(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] ctrl);
    if (b == 32'h0000_0000) begin
      fast_value = ctrl[0] ? a : 32'hFFFF_FFFF;
    end else begin
      fast_value = ctrl[0] ? 32'h0000_0000 : 32'h8000_0000;
    end
  endfunction
`endif

  assign is_div_s  = bus.i_valid && (bus.i_alum == 2'b11);
  assign accept_s  = is_div_s && !bus.i_flush;
  assign tmo_hit_s = !bus.i_div_valid && (cnt_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      a_q       <= 32'h0000_0000;
      b_q       <= 32'h0000_0000;
      alum_q    <= 2'b00;
      ctrl_q    <= 3'b000;
      cnt_q     <= 8'h00;
      result_q  <= 32'h0000_0000;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alum_q    <= alum_d;
      ctrl_q    <= ctrl_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
    end
  end

  // Flush outranks a same-cycle divider result; timeout is checked last.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    alum_d    = alum_q;
    ctrl_d    = ctrl_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          a_d    = bus.i_a;
          b_d    = bus.i_b;
          alum_d = bus.i_alum;
          ctrl_d = bus.i_alucontrol;
`ifdef DIV_FASTPATH_EN
          if (fast_hit(bus.i_a, bus.i_b, bus.i_alucontrol)) begin
            result_d = fast_value(bus.i_a, bus.i_b, bus.i_alucontrol);
            state_d  = S_DONE;
          end else begin
            state_d  = S_START;
          end
`else
          state_d = S_START;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        cnt_d = 8'h00;
        if (bus.i_flush) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.i_flush) begin
          state_d = S_IDLE;
        end else if (bus.i_div_valid) begin
          result_d = bus.i_div_result;
          state_d  = S_DONE;
        end else if (tmo_hit_s) begin
          result_d  = 32'h0000_0000;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'h01;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from state; IDLE forwards EX operands combinationally.
  always_comb begin
    bus.o_a            = a_q;
    bus.o_b            = b_q;
    bus.o_alum         = alum_q;
    bus.o_alucontrol   = ctrl_q;
    bus.o_div_start    = 1'b0;
    bus.o_div_flush    = 1'b0;
    bus.o_stall        = 1'b0;
    bus.o_result_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.o_a          = bus.i_a;
        bus.o_b          = bus.i_b;
        bus.o_alum       = bus.i_alum;
        bus.o_alucontrol = bus.i_alucontrol;
        bus.o_stall      = accept_s;
      end
      S_START: begin
        bus.o_div_start = !bus.i_flush;
        bus.o_div_flush = bus.i_flush;
        bus.o_stall     = 1'b1;
      end
      S_WAIT: begin
        bus.o_div_flush = bus.i_flush || tmo_hit_s;
        bus.o_stall     = 1'b1;
      end
      S_DONE: begin
        bus.o_result_valid = !bus.i_flush;
      end
      default: begin
        bus.o_stall = 1'b0;
      end
    endcase
  end

  assign bus.o_result  = result_q;
  assign bus.o_timeout = timeout_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq; the bench plays both EX stage
// and divider. Honors DIV_FASTPATH_EN when defined at compile time.
module tb_muldiv_seq;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  muldiv_seq_if bus_if ();

  muldiv_seq #(.DIV_TIMEOUT(40)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.i_valid      = 1'b0;
    bus_if.i_alum       = 2'b00;
    bus_if.i_alucontrol = 3'b000;
    bus_if.i_a          = 32'h0000_0000;
    bus_if.i_b          = 32'h0000_0000;
    bus_if.i_flush      = 1'b0;
    bus_if.i_div_busy   = 1'b0;
    bus_if.i_div_valid  = 1'b0;
    bus_if.i_div_result = 32'h0000_0000;
  endtask

  task automatic drive_div(input logic [31:0] a, input logic [31:0] b, input logic [2:0] ctrl);
    bus_if.i_valid      = 1'b1;
    bus_if.i_alum       = 2'b11;
    bus_if.i_alucontrol = ctrl;
    bus_if.i_a          = a;
    bus_if.i_b          = b;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #12;
    checks++;
    if ({bus_if.o_div_start, bus_if.o_div_flush, bus_if.o_stall,
         bus_if.o_result_valid, bus_if.o_timeout} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_flags got=%b want=00000", {bus_if.o_div_start, bus_if.o_div_flush,
               bus_if.o_stall, bus_if.o_result_valid, bus_if.o_timeout});
    end
    checks++;
    if (bus_if.o_result !== 32'h0000_0000) begin
      errors++;
      $display("FAIL reset_result got=%h want=00000000", bus_if.o_result);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_passthrough();
    logic [31:0] av [3];
    logic [31:0] bv [3];
    av[0] = 32'h0000_0011; bv[0] = 32'h0000_0022;
    av[1] = 32'hA5A5_0001; bv[1] = 32'h5A5A_0002;
    av[2] = 32'hFFFF_FFFF; bv[2] = 32'h8000_0000;
    for (int i = 0; i < 3; i++) begin
      bus_if.i_valid      = 1'b1;
      bus_if.i_alum       = 2'b00;
      bus_if.i_alucontrol = 3'(i);
      bus_if.i_a          = av[i];
      bus_if.i_b          = bv[i];
      #1;
      checks++;
      if (bus_if.o_stall !== 1'b0 || bus_if.o_div_start !== 1'b0) begin
        errors++;
        $display("FAIL pass_stall[%0d] stall=%b start=%b want 0/0", i, bus_if.o_stall, bus_if.o_div_start);
      end
      checks++;
      if (bus_if.o_a !== av[i] || bus_if.o_b !== bv[i] || bus_if.o_alum !== 2'b00 ||
          bus_if.o_alucontrol !== 3'(i)) begin
        errors++;
        $display("FAIL pass_ops[%0d] a=%h b=%h alum=%b ctl=%b want a=%h b=%h alum=00 ctl=%b",
                 i, bus_if.o_a, bus_if.o_b, bus_if.o_alum, bus_if.o_alucontrol, av[i], bv[i], 3'(i));
      end
      tick();
    end
    idle_inputs();
  endtask

  // Full divider path: valid arrives in WAIT cycle lat (>= 1).
  task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] ctrl, input int lat, input logic [31:0] res);
    drive_div(a, b, ctrl);
    #1;
    checks++;
    if (bus_if.o_stall !== 1'b1 || bus_if.o_div_start !== 1'b0) begin
      errors++;
      $display("FAIL %s_accept stall=%b start=%b want 1/0", name, bus_if.o_stall, bus_if.o_div_start);
    end
    tick();
    idle_inputs();
    bus_if.i_a = 32'hDEAD_BEEF;
    bus_if.i_b = 32'h1234_5678;
    #1;
    checks++;
    if (bus_if.o_div_start !== 1'b1 || bus_if.o_stall !== 1'b1 || bus_if.o_div_flush !== 1'b0) begin
      errors++;
      $display("FAIL %s_start start=%b stall=%b flush=%b want 1/1/0", name,
               bus_if.o_div_start, bus_if.o_stall, bus_if.o_div_flush);
    end
    checks++;
    if (bus_if.o_a !== a || bus_if.o_b !== b || bus_if.o_alum !== 2'b11 || bus_if.o_alucontrol !== ctrl) begin
      errors++;
      $display("FAIL %s_latch a=%h b=%h alum=%b ctl=%b want a=%h b=%h alum=11 ctl=%b", name,
               bus_if.o_a, bus_if.o_b, bus_if.o_alum, bus_if.o_alucontrol, a, b, ctrl);
    end
    for (int k = 1; k <= lat; k++) begin
      tick();
      bus_if.i_div_busy = 1'b1;
      if (k == lat) begin
        bus_if.i_div_valid  = 1'b1;
        bus_if.i_div_result = res;
      end
      #1;
      checks++;
      if (bus_if.o_stall !== 1'b1 || bus_if.o_div_start !== 1'b0 || bus_if.o_result_valid !== 1'b0 ||
          bus_if.o_div_flush !== 1'b0) begin
        errors++;
        $display("FAIL %s_wait%0d stall=%b start=%b rv=%b flush=%b want 1/0/0/0", name, k,
                 bus_if.o_stall, bus_if.o_div_start, bus_if.o_result_valid, bus_if.o_div_flush);
      end
    end
    tick();
    bus_if.i_div_valid  = 1'b0;
    bus_if.i_div_busy   = 1'b0;
    bus_if.i_div_result = 32'h0000_0000;
    #1;
    checks++;
    if (bus_if.o_result_valid !== 1'b1 || bus_if.o_result !== res || bus_if.o_stall !== 1'b0) begin
      errors++;
      $display("FAIL %s_done rv=%b res=%h stall=%b want 1/%h/0", name,
               bus_if.o_result_valid, bus_if.o_result, bus_if.o_stall, res);
    end
    tick();
    checks++;
    if (bus_if.o_result_valid !== 1'b0 || bus_if.o_result !== res) begin
      errors++;
      $display("FAIL %s_hold rv=%b res=%h want 0/%h", name, bus_if.o_result_valid, bus_if.o_result, res);
    end
  endtask

  task automatic test_div();
    run_div("udiv", 32'd100, 32'd7, 3'b100, 33, 32'd14);
    run_div("urem", 32'd100, 32'd7, 3'b101, 33, 32'd2);
  endtask

  task automatic test_flush();
    drive_div(32'd50, 32'd5, 3'b000);
    tick();
    idle_inputs();
    for (int k = 1; k <= 5; k++) begin
      tick();
      bus_if.i_div_busy = 1'b1;
    end
    bus_if.i_flush = 1'b1;
    #1;
    checks++;
    if (bus_if.o_div_flush !== 1'b1 || bus_if.o_div_start !== 1'b0) begin
      errors++;
      $display("FAIL flush_pulse flush=%b start=%b want 1/0", bus_if.o_div_flush, bus_if.o_div_start);
    end
    tick();
    bus_if.i_flush = 1'b0;
    bus_if.i_a     = 32'h0000_0777;
    #1;
    checks++;
    if (bus_if.o_div_flush !== 1'b0 || bus_if.o_stall !== 1'b0 || bus_if.o_result_valid !== 1'b0 ||
        bus_if.o_a !== 32'h0000_0777) begin
      errors++;
      $display("FAIL flush_idle flush=%b stall=%b rv=%b a=%h want 0/0/0/00000777",
               bus_if.o_div_flush, bus_if.o_stall, bus_if.o_result_valid, bus_if.o_a);
    end
    bus_if.i_div_valid  = 1'b1;
    bus_if.i_div_result = 32'd10;
    tick();
    bus_if.i_div_valid = 1'b0;
    bus_if.i_div_busy  = 1'b0;
    #1;
    checks++;
    if (bus_if.o_result_valid !== 1'b0 || bus_if.o_result !== 32'd2) begin
      errors++;
      $display("FAIL flush_late rv=%b res=%h want 0/00000002", bus_if.o_result_valid, bus_if.o_result);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_timeout();
    drive_div(32'd9, 32'd3, 3'b100);
    tick();
    idle_inputs();
    bus_if.i_div_busy = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      #1;
      if (k < 40) begin
        checks++;
        if (bus_if.o_div_flush !== 1'b0 || bus_if.o_stall !== 1'b1) begin
          errors++;
          $display("FAIL tmo_wait%0d flush=%b stall=%b want 0/1", k, bus_if.o_div_flush, bus_if.o_stall);
        end
      end else begin
        checks++;
        if (bus_if.o_div_flush !== 1'b1 || bus_if.o_timeout !== 1'b0) begin
          errors++;
          $display("FAIL tmo_abort flush=%b timeout=%b want 1/0", bus_if.o_div_flush, bus_if.o_timeout);
        end
      end
    end
    tick();
    bus_if.i_div_busy = 1'b0;
    #1;
    checks++;
    if (bus_if.o_result_valid !== 1'b1 || bus_if.o_result !== 32'h0000_0000 ||
        bus_if.o_timeout !== 1'b1 || bus_if.o_div_flush !== 1'b0) begin
      errors++;
      $display("FAIL tmo_done rv=%b res=%h timeout=%b flush=%b want 1/00000000/1/0",
               bus_if.o_result_valid, bus_if.o_result, bus_if.o_timeout, bus_if.o_div_flush);
    end
    tick();
    tick();
    checks++;
    if (bus_if.o_timeout !== 1'b1) begin
      errors++;
      $display("FAIL tmo_sticky timeout=%b want 1", bus_if.o_timeout);
    end
  endtask

`ifdef DIV_FASTPATH_EN
  task automatic fast_case(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] ctrl, input logic [31:0] res);
    drive_div(a, b, ctrl);
    #1;
    checks++;
    if (bus_if.o_stall !== 1'b1 || bus_if.o_div_start !== 1'b0) begin
      errors++;
      $display("FAIL %s_accept stall=%b start=%b want 1/0", name, bus_if.o_stall, bus_if.o_div_start);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (bus_if.o_result_valid !== 1'b1 || bus_if.o_result !== res || bus_if.o_stall !== 1'b0 ||
        bus_if.o_div_start !== 1'b0) begin
      errors++;
      $display("FAIL %s_done rv=%b res=%h stall=%b start=%b want 1/%h/0/0", name,
               bus_if.o_result_valid, bus_if.o_result, bus_if.o_stall, bus_if.o_div_start, res);
    end
    tick();
    checks++;
    if (bus_if.o_result_valid !== 1'b0 || bus_if.o_div_start !== 1'b0) begin
      errors++;
      $display("FAIL %s_after rv=%b start=%b want 0/0", name, bus_if.o_result_valid, bus_if.o_div_start);
    end
  endtask
`endif

  task automatic test_fastpath();
`ifdef DIV_FASTPATH_EN
    fast_case("fp_div0", 32'd5, 32'd0, 3'b000, 32'hFFFF_FFFF);
    fast_case("fp_rem0", 32'd5, 32'd0, 3'b001, 32'd5);
    fast_case("fp_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 3'b000, 32'h8000_0000);
`else
    run_div("sl_div0", 32'd5, 32'd0, 3'b000, 4, 32'hFFFF_FFFF);
    run_div("sl_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 3'b000, 3, 32'h8000_0000);
`endif
  endtask

  task automatic test_back_to_back();
    drive_div(32'd20, 32'd3, 3'b100);
    tick();
    #1;
    checks++;
    if (bus_if.o_div_start !== 1'b1) begin
      errors++;
      $display("FAIL b2b_start1 start=%b want 1", bus_if.o_div_start);
    end
    tick();
    bus_if.i_div_valid  = 1'b1;
    bus_if.i_div_result = 32'd6;
    tick();
    bus_if.i_div_valid = 1'b0;
    bus_if.i_a         = 32'd45;
    bus_if.i_b         = 32'd5;
    #1;
    checks++;
    if (bus_if.o_result_valid !== 1'b1 || bus_if.o_result !== 32'd6 || bus_if.o_stall !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done1 rv=%b res=%h stall=%b want 1/00000006/0",
               bus_if.o_result_valid, bus_if.o_result, bus_if.o_stall);
    end
    tick();
    checks++;
    if (bus_if.o_stall !== 1'b1 || bus_if.o_div_start !== 1'b0 || bus_if.o_result_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept2 stall=%b start=%b rv=%b want 1/0/0",
               bus_if.o_stall, bus_if.o_div_start, bus_if.o_result_valid);
    end
    tick();
    bus_if.i_valid = 1'b0;
    #1;
    checks++;
    if (bus_if.o_div_start !== 1'b1 || bus_if.o_a !== 32'd45 || bus_if.o_b !== 32'd5) begin
      errors++;
      $display("FAIL b2b_start2 start=%b a=%h b=%h want 1/0000002d/00000005",
               bus_if.o_div_start, bus_if.o_a, bus_if.o_b);
    end
    tick();
    tick();
    bus_if.i_div_valid  = 1'b1;
    bus_if.i_div_result = 32'd9;
    tick();
    bus_if.i_div_valid = 1'b0;
    #1;
    checks++;
    if (bus_if.o_result_valid !== 1'b1 || bus_if.o_result !== 32'd9) begin
      errors++;
      $display("FAIL b2b_done2 rv=%b res=%h want 1/00000009", bus_if.o_result_valid, bus_if.o_result);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_flush_done();
    drive_div(32'd8, 32'd2, 3'b100);
    tick();
    idle_inputs();
    tick();
    bus_if.i_div_valid  = 1'b1;
    bus_if.i_div_result = 32'd4;
    tick();
    bus_if.i_div_valid = 1'b0;
    bus_if.i_flush     = 1'b1;
    #1;
    checks++;
    if (bus_if.o_result_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_done rv=%b want 0", bus_if.o_result_valid);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    drive_div(32'd77, 32'd7, 3'b100);
    tick();
    idle_inputs();
    tick();
    bus_if.i_div_busy = 1'b1;
    tick();
    rst = 1'b0;
    bus_if.i_div_busy = 1'b0;
    #1;
    checks++;
    if ({bus_if.o_div_start, bus_if.o_div_flush, bus_if.o_stall,
         bus_if.o_result_valid, bus_if.o_timeout} !== 5'b00000 || bus_if.o_result !== 32'h0000_0000) begin
      errors++;
      $display("FAIL rstmid_outs flags=%b res=%h want 00000/00000000", {bus_if.o_div_start,
               bus_if.o_div_flush, bus_if.o_stall, bus_if.o_result_valid, bus_if.o_timeout}, bus_if.o_result);
    end
    tick();
    rst = 1'b1;
    tick();
    run_div("post_rst", 32'hFFFF_FF9C, 32'd7, 3'b000, 5, 32'hFFFF_FFF2);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_passthrough();
    test_div();
    test_flush();
    test_timeout();
    test_fastpath();
    test_back_to_back();
    test_flush_done();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "bench time limit");
  end

endmodule
